// File: rtl/sha1_digest_check.sv
// SHA-1 digest finisher: captures rounds 76..80, adds the IV, masks and compares, and holds the result in a valid/ready register.
// Optional SHA1_DIGEST_OUT_EN macro adds the registered 160-bit out_digest port.
module sha1_digest_check #(
  parameter int CMP_WORDS  = 2,
  parameter bit MATCH_ONLY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  A,
  input  logic         round_start,
  input  logic [31:0]  tag_in,
  input  logic [159:0] target,
  input  logic [159:0] mask,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_match,
  output logic [31:0]  out_tag,
  output logic         overrun
`ifdef SHA1_DIGEST_OUT_EN
  ,
  output logic [159:0] out_digest
`endif
);

  localparam logic [159:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};

`ifdef SHA1_DIGEST_OUT_EN
  localparam int KEEP_W = 5;
`else
  localparam int KEEP_W = CMP_WORDS;
`endif

  if (CMP_WORDS < 1 || CMP_WORDS > 5) begin : g_bad_cmp_words
    $error("sha1_digest_check: CMP_WORDS must be in 1..5");
  end

  logic [6:0]  rc_q, rc_d, rc_cur;
  logic [31:0] tag_q, tag_d;
  logic        last_round;
  logic [31:0] hist_q [4];
  logic [31:0] cap [5];
  logic        s1_valid_q;
  logic [31:0] s1_tag_q;
  logic [31:0] h_w [5];
  logic [4:0]  hit;
  logic        match;

  logic        out_valid_q, out_valid_d;
  logic        out_match_q, out_match_d;
  logic [31:0] out_tag_q, out_tag_d;
  logic        overrun_q, overrun_d;
  logic        emit, accept, load;

  // rc_cur is the round number of the A value present this cycle; round_start makes it 1 immediately.
  always_comb begin
    rc_cur = round_start ? 7'd1 : rc_q;
    rc_d   = (rc_cur == 7'd0 || rc_cur == 7'd80) ? 7'd0 : rc_cur + 7'd1;
    tag_d  = round_start ? tag_in : tag_q;
  end

  assign last_round = (rc_cur == 7'd80);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q       <= 7'd0;
      tag_q      <= 32'd0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 32'd0;
    end else begin
      rc_q       <= rc_d;
      tag_q      <= tag_d;
      s1_valid_q <= last_round;
      if (last_round) s1_tag_q <= tag_q;
    end
  end

  always_ff @(posedge clk) begin
    hist_q[0] <= A;
    hist_q[1] <= hist_q[0];
    hist_q[2] <= hist_q[1];
    hist_q[3] <= hist_q[2];
  end

  // Working variables at round 80: a=A80, b=A79, c..e are A78..A76 rotated left by 30.
  assign cap[0] = A;
  assign cap[1] = hist_q[0];
  assign cap[2] = {hist_q[1][1:0], hist_q[1][31:2]};
  assign cap[3] = {hist_q[2][1:0], hist_q[2][31:2]};
  assign cap[4] = {hist_q[3][1:0], hist_q[3][31:2]};

  genvar gi;
  for (gi = 0; gi < 5; gi++) begin : g_word
    logic [31:0] t_w, m_w;
    assign t_w = target[159-32*gi -: 32];
    assign m_w = mask[159-32*gi -: 32];

    if (gi < KEEP_W) begin : g_h
      logic [31:0] h_q;
      always_ff @(posedge clk) begin
        if (last_round) h_q <= IV[159-32*gi -: 32] + cap[gi];
      end
      assign h_w[gi] = h_q;
    end else begin : g_no_h
      assign h_w[gi] = 32'd0;
    end

    if (gi < CMP_WORDS) begin : g_cmp
      assign hit[gi] = (((h_w[gi] ^ t_w) & m_w) == 32'd0);
    end else begin : g_skip
      logic unused_word;
      assign unused_word = ^{t_w, m_w, h_w[gi], cap[gi]};
      assign hit[gi]     = 1'b1;
    end
  end

  assign match = &hit;

  always_comb begin
    emit        = s1_valid_q && (!MATCH_ONLY || match);
    accept      = out_valid_q && out_ready;
    load        = 1'b0;
    out_valid_d = out_valid_q;
    out_match_d = out_match_q;
    out_tag_d   = out_tag_q;
    overrun_d   = overrun_q;
    if (emit && (!out_valid_q || accept)) begin
      load        = 1'b1;
      out_valid_d = 1'b1;
      out_match_d = match;
      out_tag_d   = s1_tag_q;
    end else begin
      if (emit)   overrun_d   = 1'b1;
      if (accept) out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_match_q <= 1'b0;
      out_tag_q   <= 32'd0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_match_q <= out_match_d;
      out_tag_q   <= out_tag_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_match = out_match_q;
  assign out_tag   = out_tag_q;
  assign overrun   = overrun_q;

`ifdef SHA1_DIGEST_OUT_EN
  logic [159:0] out_digest_q, out_digest_d;

  always_comb begin
    out_digest_d = out_digest_q;
    if (load) out_digest_d = {h_w[0], h_w[1], h_w[2], h_w[3], h_w[4]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_digest_q <= 160'd0;
    else     out_digest_q <= out_digest_d;
  end

  assign out_digest = out_digest_q;
`else
  logic unused_load;
  assign unused_load = load;
`endif

endmodule

// File: tb/tb_sha1_digest_check.sv
// Directed bench for sha1_digest_check using the SHA-1 "abc" round trace (A1..A80 derived from the padded block).
// Two instances share stimulus: MATCH_ONLY=1 and MATCH_ONLY=0.
module tb_sha1_digest_check;

  localparam logic [159:0] ABC_DIGEST =
    {32'ha9993e36, 32'h4706816a, 32'hba3e2571, 32'h7850c26c, 32'h9cd0d89d};

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  A;
  logic         round_start;
  logic [31:0]  tag_in;
  logic [159:0] target;
  logic [159:0] mask;
  logic         out_ready;

  logic         v1, m1, ov1;
  logic [31:0]  t1;
  logic         v0, m0, ov0;
  logic [31:0]  t0;
`ifdef SHA1_DIGEST_OUT_EN
  logic [159:0] d1, d0;
`endif

  sha1_digest_check #(.CMP_WORDS(2), .MATCH_ONLY(1'b1)) dut (
    .clk(clk), .rst(rst), .A(A), .round_start(round_start), .tag_in(tag_in),
    .target(target), .mask(mask), .out_valid(v1), .out_ready(out_ready),
    .out_match(m1), .out_tag(t1), .overrun(ov1)
`ifdef SHA1_DIGEST_OUT_EN
    , .out_digest(d1)
`endif
  );

  sha1_digest_check #(.CMP_WORDS(2), .MATCH_ONLY(1'b0)) dut_all (
    .clk(clk), .rst(rst), .A(A), .round_start(round_start), .tag_in(tag_in),
    .target(target), .mask(mask), .out_valid(v0), .out_ready(out_ready),
    .out_match(m0), .out_tag(t0), .overrun(ov0)
`ifdef SHA1_DIGEST_OUT_EN
    , .out_digest(d0)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] gold [1:80];

  bit          collect = 1'b0;
  logic [31:0] got_tag [$];
  int          got_cyc [$];

  always @(negedge clk) begin
    if (collect && v1 && out_ready) begin
      got_tag.push_back(t1);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference SHA-1 compression of the single padded "abc" block; records the new A after each round.
  task automatic build_gold();
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int i = 0; i < 16; i++) w[i] = 32'd0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int i = 16; i < 80; i++) begin
      tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {tmp[30:0], tmp[31]};
    end
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476; e = 32'hc3d2e1f0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
      gold[i+1] = tmp;
    end
  endtask

  task automatic feed_rounds(input int first, input int last, input bit start_first, input logic [31:0] tag);
    for (int r = first; r <= last; r++) begin
      round_start = start_first && (r == first);
      tag_in      = tag;
      A           = gold[r];
      step();
    end
    round_start = 1'b0;
    A           = 32'hdeadbeef;
  endtask

  task automatic feed_job(input logic [31:0] tag);
    feed_rounds(1, 80, 1'b1, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic accept_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; A = 32'd0; round_start = 1'b0; tag_in = 32'd0;
    target = ABC_DIGEST; mask = {160{1'b1}}; out_ready = 1'b0;
    build_gold();
    do_reset();

    chk("reset out_valid", {158'd0, v1, v0}, 160'd0);
    chk("reset out_match", {158'd0, m1, m0}, 160'd0);
    chk("reset out_tag",   {96'd0, t1, t0},  160'd0);
    chk("reset overrun",   {158'd0, ov1, ov0}, 160'd0);
`ifdef SHA1_DIGEST_OUT_EN
    chk("reset out_digest", d1, 160'd0);
`endif

    // "abc", full mask, expected digest as target
    feed_job(32'h00000042);
    chk("abc valid before cycle 81", {159'd0, v1}, 160'd0);
    step();
    chk("abc valid at cycle 81", {159'd0, v1}, 160'd1);
    chk("abc match",             {159'd0, m1}, 160'd1);
    chk("abc tag",               {128'd0, t1}, 160'h42);
    chk("abc all-emit match",    {159'd0, m0}, 160'd1);
`ifdef SHA1_DIGEST_OUT_EN
    chk("abc digest", d1, ABC_DIGEST);
`endif
    accept_one();
    chk("abc accepted, valid low", {158'd0, v1, v0}, 160'd0);

    // T1 off by one bit
    target = {32'ha9993e36, 32'h4706816b, 96'd0};
    feed_job(32'h00000043);
    step();
    chk("miss match-only valid", {159'd0, v1}, 160'd0);
    chk("miss all-emit valid",   {159'd0, v0}, 160'd1);
    chk("miss all-emit match",   {159'd0, m0}, 160'd0);
    chk("miss all-emit tag",     {128'd0, t0}, 160'h43);
    step();
    step();
    chk("miss match-only stays low", {159'd0, v1}, 160'd0);
    accept_one();

    // Word 1 masked out entirely, T1=0
    target = {32'ha9993e36, 32'h00000000, 96'd0};
    mask   = {32'hffffffff, 32'h00000000, 96'hffffffff_ffffffff_ffffffff};
    feed_job(32'h00000044);
    step();
    chk("masked valid", {159'd0, v1}, 160'd1);
    chk("masked match", {159'd0, m1}, 160'd1);
    accept_one();

    // Two jobs, consumer stalled: second result is dropped
    target = ABC_DIGEST;
    mask   = {160{1'b1}};
    feed_job(32'h00000001);
    feed_job(32'h00000002);
    chk("stall held first valid", {159'd0, v1}, 160'd1);
    chk("stall no overrun yet",   {159'd0, ov1}, 160'd0);
    step();
    chk("stall overrun set",  {159'd0, ov1}, 160'd1);
    chk("stall tag is first", {128'd0, t1}, 160'h1);
    repeat (5) step();
    chk("stall valid held", {159'd0, v1}, 160'd1);
    chk("stall tag held",   {128'd0, t1}, 160'h1);
    chk("stall match held", {159'd0, m1}, 160'd1);
    accept_one();
    chk("stall accepted, valid low", {159'd0, v1}, 160'd0);
    chk("overrun sticky",            {159'd0, ov1}, 160'd1);
    do_reset();
    chk("overrun cleared by rst", {159'd0, ov1}, 160'd0);

    // Restart at rc=40 with tag 7
    feed_rounds(1, 39, 1'b1, 32'h00000005);
    feed_job(32'h00000007);
    chk("restart no early result", {159'd0, v0}, 160'd0);
    step();
    chk("restart valid", {159'd0, v1}, 160'd1);
    chk("restart tag",   {128'd0, t1}, 160'h7);
    chk("restart match", {159'd0, m1}, 160'd1);
    repeat (3) step();
    chk("restart single result", {159'd0, ov0}, 160'd0);

    // Async reset at rc=60 while a result is held
    feed_rounds(1, 59, 1'b1, 32'h00000009);
    chk("pre-rst result held", {128'd0, t1}, 160'h7);
    rst = 1'b1;
    #1;
    chk("async rst valid", {158'd0, v1, v0}, 160'd0);
    chk("async rst match", {158'd0, m1, m0}, 160'd0);
    chk("async rst tag",   {96'd0, t1, t0}, 160'd0);
    step();
    rst = 1'b0;
    feed_rounds(60, 80, 1'b0, 32'h00000009);
    repeat (4) step();
    chk("abandoned job no output", {158'd0, v1, v0}, 160'd0);
    chk("abandoned job overrun",   {158'd0, ov1, ov0}, 160'd0);

    // Four back-to-back jobs, consumer always ready
    out_ready = 1'b1;
    collect   = 1'b1;
    for (int j = 0; j < 4; j++) feed_job(32'h00000100 + j);
    repeat (4) step();
    collect   = 1'b0;
    out_ready = 1'b0;
    chk("b2b result count", 160'(got_tag.size()), 160'd4);
    for (int j = 0; j < 4 && j < got_tag.size(); j++) begin
      chk($sformatf("b2b tag %0d", j), {128'd0, got_tag[j]}, 160'(32'h100 + j));
      if (j > 0) chk($sformatf("b2b spacing %0d", j), 160'(got_cyc[j] - got_cyc[j-1]), 160'd80);
    end
    chk("b2b overrun", {158'd0, ov1, ov0}, 160'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
